// File: rtl/alu_arbiter_if.sv
// Bundle of both requester channels plus the shared-alu port of alu_arbiter.
// The slave modport is the arbiter's view; master is the requesters/alu side.
interface alu_arbiter_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SEL_W = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [SEL_W-1:0] req0_sel;
    logic             rsp0_valid;
    logic             rsp0_ready;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [SEL_W-1:0] req1_sel;
    logic             rsp1_valid;
    logic             rsp1_ready;

    logic [WIDTH-1:0] rsp_out;
    logic             rsp_zero;
    logic             rsp_err;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [SEL_W-1:0] alu_sel;
    logic [WIDTH-1:0] alu_out;
    logic             alu_zero;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sel, rsp0_ready,
        input  req1_valid, req1_a, req1_b, req1_sel, rsp1_ready,
        input  alu_out, alu_zero,
        output req0_ready, rsp0_valid, req1_ready, rsp1_valid,
        output rsp_out, rsp_zero, rsp_err,
        output alu_a, alu_b, alu_sel
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_sel, rsp0_ready,
        output req1_valid, req1_a, req1_b, req1_sel, rsp1_ready,
        output alu_out, alu_zero,
        input  req0_ready, rsp0_valid, req1_ready, rsp1_valid,
        input  rsp_out, rsp_zero, rsp_err,
        input  alu_a, alu_b, alu_sel
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational alu between two valid/ready requesters.
// Define ALU_ARB_OPCHK_EN to reject illegal opcodes with RspErr instead of running them.
module alu_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SEL_W = 4
) (
    input logic           clk,
    input logic           rst,
    alu_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e           state_q, state_d;
    logic             last_gnt_q, last_gnt_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [SEL_W-1:0] alu_sel_q, alu_sel_d;
    logic [WIDTH-1:0] rsp_out_q, rsp_out_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_err_q, rsp_err_d;

    logic             gnt;
    logic             hs;
    logic             opc_ok;
    logic [WIDTH-1:0] gnt_a;
    logic [WIDTH-1:0] gnt_b;
    logic [SEL_W-1:0] gnt_sel;

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        gnt     = (bus.req0_valid && bus.req1_valid) ? ~last_gnt_q : bus.req1_valid;
        hs      = (state_q == StIdle) && (bus.req0_valid || bus.req1_valid);
        gnt_a   = gnt ? bus.req1_a   : bus.req0_a;
        gnt_b   = gnt ? bus.req1_b   : bus.req0_b;
        gnt_sel = gnt ? bus.req1_sel : bus.req0_sel;
    end

`ifdef ALU_ARB_OPCHK_EN
    always_comb begin
        opc_ok = (gnt_sel == SEL_W'(4'b0000)) || (gnt_sel == SEL_W'(4'b0001)) ||
                 (gnt_sel == SEL_W'(4'b0010)) || (gnt_sel == SEL_W'(4'b0110));
    end
`else
    assign opc_ok = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        owner_d    = owner_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_sel_d  = alu_sel_q;
        rsp_out_d  = rsp_out_q;
        rsp_zero_d = rsp_zero_q;
        rsp_err_d  = rsp_err_q;
        unique case (state_q)
            StIdle: begin
                if (hs) begin
                    last_gnt_d = gnt;
                    owner_d    = gnt;
                    if (opc_ok) begin
                        alu_a_d   = gnt_a;
                        alu_b_d   = gnt_b;
                        alu_sel_d = gnt_sel;
                        state_d   = StExec;
                    end else begin
                        // Rejected op answers directly; alu operand registers keep old values.
                        rsp_out_d  = '0;
                        rsp_zero_d = 1'b0;
                        rsp_err_d  = 1'b1;
                        state_d    = StResp;
                    end
                end
            end
            StExec: begin
                rsp_out_d  = bus.alu_out;
                rsp_zero_d = bus.alu_zero;
                rsp_err_d  = 1'b0;
                state_d    = StResp;
            end
            StResp: begin
                if (owner_q ? bus.rsp1_ready : bus.rsp0_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            last_gnt_q <= 1'b1;
            owner_q    <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_sel_q  <= '0;
            rsp_out_q  <= '0;
            rsp_zero_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            owner_q    <= owner_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_sel_q  <= alu_sel_d;
            rsp_out_q  <= rsp_out_d;
            rsp_zero_q <= rsp_zero_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign bus.req0_ready = ~rst & hs & ~gnt;
    assign bus.req1_ready = ~rst & hs & gnt;
    assign bus.rsp0_valid = ~rst & (state_q == StResp) & ~owner_q;
    assign bus.rsp1_valid = ~rst & (state_q == StResp) & owner_q;
    assign bus.rsp_out    = rsp_out_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_sel    = alu_sel_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios then random traffic against a transaction model.
// Expectations follow ALU_ARB_OPCHK_EN when the bench is built with it defined.
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    alu_arbiter_if #(.WIDTH(8), .SEL_W(4)) bus ();

    alu_arbiter #(.WIDTH(8), .SEL_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference alu; undefined opcodes give XOR so they are observable.
    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] s);
        case (s)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            default: return a ^ b;
        endcase
    endfunction

    assign bus.alu_out  = alu_f(bus.alu_a, bus.alu_b, bus.alu_sel);
    assign bus.alu_zero = (bus.alu_out == 8'h00);

    // Transaction model: one outstanding op, response visible lat cycles after acceptance.
    bit       m_busy   = 1'b0;
    bit       m_owner  = 1'b0;
    bit       m_last   = 1'b1;
    bit       m_known  = 1'b0;
    int       m_age    = 0;
    int       m_lat    = 2;
    bit [7:0] m_out    = '0;
    bit       m_zero   = 1'b0;
    bit       m_err    = 1'b0;
    bit [7:0] m_alu_a  = '0;
    bit [7:0] m_alu_b  = '0;
    bit [3:0] m_alu_s  = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r,
                        input bit v0, input bit [7:0] a0, input bit [7:0] b0, input bit [3:0] s0,
                        input bit k0,
                        input bit v1, input bit [7:0] a1, input bit [7:0] b1, input bit [3:0] s1,
                        input bit k1);
        bit       g;
        bit       hs;
        bit       rv;
        bit       ill;
        bit [7:0] sa;
        bit [7:0] sb;
        bit [3:0] ss;
        rst = r;
        bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_sel = s0;
        bus.rsp0_ready = k0;
        bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_sel = s1;
        bus.rsp1_ready = k1;
        #1;
        g  = (v0 && v1) ? !m_last : v1;
        hs = !r && !m_busy && (v0 || v1);
        rv = !r && m_busy && (m_age >= m_lat);
        chk("req0_ready", {31'd0, bus.req0_ready}, {31'd0, hs && !g});
        chk("req1_ready", {31'd0, bus.req1_ready}, {31'd0, hs && g});
        chk("rsp0_valid", {31'd0, bus.rsp0_valid}, {31'd0, rv && !m_owner});
        chk("rsp1_valid", {31'd0, bus.rsp1_valid}, {31'd0, rv && m_owner});
        if (rv) begin
            chk("rsp_out", {24'd0, bus.rsp_out}, {24'd0, m_out});
            chk("rsp_zero", {31'd0, bus.rsp_zero}, {31'd0, m_zero});
            chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, m_err});
        end
        if (m_known) begin
            chk("alu_a", {24'd0, bus.alu_a}, {24'd0, m_alu_a});
            chk("alu_b", {24'd0, bus.alu_b}, {24'd0, m_alu_b});
            chk("alu_sel", {28'd0, bus.alu_sel}, {28'd0, m_alu_s});
        end
        @(posedge clk);
        if (r) begin
            m_busy = 1'b0; m_last = 1'b1; m_owner = 1'b0; m_known = 1'b1;
            m_alu_a = '0; m_alu_b = '0; m_alu_s = '0;
        end else if (hs) begin
            sa = g ? a1 : a0; sb = g ? b1 : b0; ss = g ? s1 : s0;
            m_busy = 1'b1; m_owner = g; m_last = g; m_age = 1;
            ill = 1'b0;
`ifdef ALU_ARB_OPCHK_EN
            ill = !(ss inside {4'b0000, 4'b0001, 4'b0010, 4'b0110});
`endif
            if (ill) begin
                m_lat = 1; m_out = '0; m_zero = 1'b0; m_err = 1'b1;
            end else begin
                m_lat = 2; m_out = alu_f(sa, sb, ss); m_zero = (m_out == 8'h00); m_err = 1'b0;
                m_alu_a = sa; m_alu_b = sb; m_alu_s = ss;
            end
        end else if (m_busy) begin
            if (m_age >= m_lat && (m_owner ? k1 : k0)) m_busy = 1'b0;
            else if (m_age < m_lat) m_age++;
        end
        #1;
    endtask

    task automatic idle(input bit k0, input bit k1);
        step(1'b0, 1'b0, 8'h00, 8'h00, 4'h0, k0, 1'b0, 8'h00, 8'h00, 4'h0, k1);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0);
    endtask

    initial begin
        bit [3:0] rs0;
        bit [3:0] rs1;
        do_reset();
        do_reset();
        chk("rst_rsp_out", {24'd0, bus.rsp_out}, 32'h0);
        chk("rst_rsp_zero", {31'd0, bus.rsp_zero}, 32'h0);
        chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'h0);

        // Single requester AND, result two cycles after handshake.
        step(1'b0, 1'b1, 8'hCC, 8'hAA, 4'b0000, 1'b1, 1'b0, 8'h00, 8'h00, 4'h0, 1'b1);
        idle(1'b1, 1'b1);
        chk("and_valid", {31'd0, bus.rsp0_valid}, 32'h1);
        chk("and_out", {24'd0, bus.rsp_out}, 32'h88);
        idle(1'b1, 1'b1);

        // Requester 1 ADD then SUB to zero.
        step(1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 1'b1, 1'b1, 8'h55, 8'hAA, 4'b0010, 1'b1);
        idle(1'b1, 1'b1);
        chk("add_out", {24'd0, bus.rsp_out}, 32'hFF);
        idle(1'b1, 1'b1);
        step(1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 1'b1, 1'b1, 8'hFF, 8'hFF, 4'b0110, 1'b1);
        idle(1'b1, 1'b1);
        chk("sub_zero", {31'd0, bus.rsp_zero}, 32'h1);
        idle(1'b1, 1'b1);

        // Tie after reset: requester 0 first, then alternation.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b1, 8'h01, 8'h02, 4'b0010, 1'b1, 1'b1, 8'h00, 8'h00, 4'b0001, 1'b1);
            if (i == 1) chk("tie_first_out", {24'd0, bus.rsp_out}, 32'h03);
            if (i == 4) chk("tie_second_zero", {31'd0, bus.rsp_zero}, 32'h1);
        end
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);

        // Backpressure on requester 0 while requester 1 waits.
        for (int i = 0; i < 7; i++)
            step(1'b0, i == 0, 8'h0F, 8'h33, 4'b0001, 1'b0, 1'b1, 8'h10, 8'h01, 4'b0110, 1'b1);
        step(1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 1'b1, 1'b1, 8'h10, 8'h01, 4'b0110, 1'b1);
        step(1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 1'b1, 1'b1, 8'h10, 8'h01, 4'b0110, 1'b1);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);

        // Reset while an op is executing.
        step(1'b0, 1'b1, 8'h77, 8'h11, 4'b0010, 1'b1, 1'b0, 8'h00, 8'h00, 4'h0, 1'b1);
        do_reset();
        idle(1'b1, 1'b1);
        chk("midrst_out", {24'd0, bus.rsp_out}, 32'h0);
        step(1'b0, 1'b1, 8'h0A, 8'h03, 4'b0110, 1'b1, 1'b0, 8'h00, 8'h00, 4'h0, 1'b1);
        idle(1'b1, 1'b1);
        chk("midrst_sub", {24'd0, bus.rsp_out}, 32'h07);
        idle(1'b1, 1'b1);

        // Undefined opcode.
        step(1'b0, 1'b1, 8'hAA, 8'h55, 4'b1111, 1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0);
`ifdef ALU_ARB_OPCHK_EN
        chk("ill_valid", {31'd0, bus.rsp0_valid}, 32'h1);
        chk("ill_err", {31'd0, bus.rsp_err}, 32'h1);
        chk("ill_out", {24'd0, bus.rsp_out}, 32'h0);
`else
        idle(1'b0, 1'b0);
        chk("ill_err", {31'd0, bus.rsp_err}, 32'h0);
        chk("ill_out", {24'd0, bus.rsp_out}, 32'hFF);
`endif
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rs0 = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
            rs1 = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
            if (rs0 == 4'd3) rs0 = 4'b0110;
            if (rs1 == 4'd3) rs1 = 4'b0110;
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 2) != 0, 8'($urandom), 8'($urandom), rs0,
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 2) != 0, 8'($urandom), 8'($urandom), rs1,
                 $urandom_range(0, 2) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares a single combinational alu instance (A/B/Sel in, Out/Zero back) between two requesters. Each requester uses a valid/ready request channel and a valid/ready response channel. A round-robin arbiter picks one request at a time and sequences it through the ALU. The block registers the operands, captures the result and holds the response until the owning requester accepts it. Sits between pipeline front-ends and the shared alu.

Parameters:
WIDTH, 8, operand/result width; must match the alu datapath
SEL_W, 4, opcode width; must match alu Sel

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
Req0Valid  input  1  requester 0 has an operation
Req0Ready  output  1  arbiter accepts requester 0 this cycle
Req0A  input  WIDTH  operand A, requester 0
Req0B  input  WIDTH  operand B, requester 0
Req0Sel  input  SEL_W  opcode, requester 0
Rsp0Valid  output  1  result for requester 0 available
Rsp0Ready  input  1  requester 0 takes result
Req1Valid, Req1Ready, Req1A, Req1B, Req1Sel, Rsp1Valid, Rsp1Ready: same as above, for requester 1
RspOut  output  WIDTH  captured result (shared by both response channels)
RspZero  output  1  captured Zero flag
RspErr  output  1  opcode rejected (0 unless ALU_ARB_OPCHK_EN is defined)
AluA  output  WIDTH  to alu A (registered)
AluB  output  WIDTH  to alu B (registered)
AluSel  output  SEL_W  to alu Sel (registered)
AluOut  input  WIDTH  from alu Out
AluZero  input  1  from alu Zero

Behaviour:
- Opcodes: 0000 AND, 0001 OR, 0010 ADD (mod 2^WIDTH, carry dropped), 0110 SUB (mod 2^WIDTH, borrow dropped). The arbiter never computes results; it only sequences the alu.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Grant is combinational from Req*Valid and the LastGnt register.
  - Only one valid: grant it.
  - Both valid: grant the requester that is not LastGnt.
  - ReqNReady = (state==IDLE) && grant==N. At most one Ready is high in any cycle.
  - On handshake: latch A/B/Sel into the AluA/AluB/AluSel registers, store Owner=N and LastGnt=N, go to EXEC.
- EXEC (one cycle): alu inputs are stable. At the clock edge, capture AluOut into RspOut and AluZero into RspZero, then go to RESP.
- RESP:
  - RspNValid=1 for N==Owner; the other Rsp*Valid stays 0.
  - RspOut/RspZero/RspErr are held stable until RspNReady=1. Then go to IDLE.
  - Rsp Ready from the non-owner is ignored.
- Latency: handshake in cycle T -> RspValid high in cycle T+2. Peak throughput is one op per 3 cycles, achieved when RspReady is held high.
- Ready is low in EXEC and RESP. A request held valid during that time is granted on the next IDLE cycle.
- Requester inputs are sampled only at the handshake. Later changes do not affect an in-flight op.
- Reset (rst=1 at a clock edge, any state):
  - state=IDLE, LastGnt=1 (requester 0 wins the first tie), Owner=0.
  - AluA/AluB/AluSel=0, RspOut=0, RspZero=0, RspErr=0, all Valid/Ready outputs 0 in the following cycle.
  - An in-flight op is discarded and no response is issued.
- Ready and Valid outputs are forced 0 while rst is high.

Optional Feature:
ALU_ARB_OPCHK_EN
- Defined:
  - The IDLE handshake checks Sel against {0000,0001,0010,0110}.
  - An illegal opcode is still accepted and LastGnt still updates, but the FSM skips EXEC and goes IDLE -> RESP.
  - Response values: RspErr=1, RspOut=0, RspZero=0. AluA/AluB/AluSel keep their previous values.
  - Latency is T+1. A legal op gives RspErr=0.
- Not defined: all opcodes pass to the alu unchanged, and RspErr is tied 0.

Test Plan:
- Single requester: Req0 AND, A=0xCC, B=0xAA -> Rsp0Valid two cycles after the handshake, RspOut=0x88, RspZero=0; Rsp1Valid stays 0.
- Req1 ADD 0x55+0xAA -> RspOut=0xFF, RspZero=0. Then Req1 SUB 0xFF-0xFF -> RspOut=0x00, RspZero=1.
- Tie after reset:
  - Req0 ADD 0x01+0x02 and Req1 OR 0x00|0x00 both valid -> Req0 served first, RspOut=0x03.
  - Req1 served next, RspOut=0x00, RspZero=1.
  - A repeated tie then grants Req0 (alternation).
- Backpressure: hold Rsp0Ready=0 for 5 cycles -> Rsp0Valid and RspOut stay stable, Req0Ready/Req1Ready stay 0. Release -> IDLE on the next cycle.
- Reset mid-op: assert rst during EXEC -> no Rsp*Valid is issued, all outputs are 0. A fresh SUB 0x0A-0x03 afterwards -> RspOut=0x07.
- With ALU_ARB_OPCHK_EN defined: Req0 Sel=1111, A=0xAA, B=0x55 -> Rsp0Valid one cycle after the handshake, RspErr=1, RspOut=0x00, RspZero=0. Without the macro -> RspErr=0 and RspOut = whatever the alu drives.
